// File: rtl/r_type_issue_unit.sv
// r_type_issue_unit: issue/writeback controller for the registered R-type ALU.
// Accepts one instruction word, reads rs1/rs2, drives the ALU, then either
// writes rd and retires, or flags an illegal instruction.
// Optional macro R_TYPE_ISSUE_OVERLAP_EN: also accept a new word in
// WRITEBACK/ILLEGAL so issue overlaps the final cycle (1 per 3 cycles).
module r_type_issue_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter logic [6:0]  OP_OPCODE      = 7'b0110011
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instr_word,
  output logic [REG_ADDR_WIDTH-1:0] rs1_index,
  output logic [REG_ADDR_WIDTH-1:0] rs2_index,
  input  logic [DATA_WIDTH-1:0]     rs1_value,
  input  logic [DATA_WIDTH-1:0]     rs2_value,
  output logic [2:0]                alu_subfunction_3,
  output logic [6:0]                alu_subfunction_7,
  output logic [DATA_WIDTH-1:0]     alu_operand1,
  output logic [DATA_WIDTH-1:0]     alu_operand2,
  input  logic                      alu_error,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  output logic                      rd_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] rd_index,
  output logic [DATA_WIDTH-1:0]     rd_write_data,
  output logic                      retire,
  output logic                      illegal_instruction,
  output logic [31:0]               illegal_instruction_word,
  output logic                      busy
);

`ifdef R_TYPE_ISSUE_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    ILLEGAL   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [31:0]           instr_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [31:0]           illegal_word_q;
  logic                  accept;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Instruction latch, operand capture in DECODE, illegal-word capture on entry to ILLEGAL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q        <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      illegal_word_q <= '0;
    end else begin
      if (accept) instr_q <= instr_word;
      if (state == DECODE) begin
        op1_q <= rs1_value;
        op2_q <= rs2_value;
      end
      if (state_next == ILLEGAL) illegal_word_q <= instr_q;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next          = state;
    instr_ready         = 1'b0;
    rd_write_enable     = 1'b0;
    rd_write_data       = '0;
    retire              = 1'b0;
    illegal_instruction = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = DECODE;
      end
      DECODE: begin
        state_next = (instr_q[6:0] == OP_OPCODE) ? EXECUTE : ILLEGAL;
      end
      EXECUTE: begin
        state_next = alu_error ? ILLEGAL : WRITEBACK;
      end
      WRITEBACK: begin
        rd_write_enable = (instr_q[11:7] != 5'd0);
        rd_write_data   = alu_result;
        retire          = 1'b1;
        instr_ready     = OVERLAP;
        state_next      = (OVERLAP && instr_valid) ? DECODE : IDLE;
      end
      ILLEGAL: begin
        illegal_instruction = 1'b1;
        instr_ready         = OVERLAP;
        state_next          = (OVERLAP && instr_valid) ? DECODE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept                   = instr_valid & instr_ready;
  assign rs1_index                = REG_ADDR_WIDTH'(instr_q[19:15]);
  assign rs2_index                = REG_ADDR_WIDTH'(instr_q[24:20]);
  assign rd_index                 = REG_ADDR_WIDTH'(instr_q[11:7]);
  assign alu_subfunction_3        = instr_q[14:12];
  assign alu_subfunction_7        = instr_q[31:25];
  assign alu_operand1             = op1_q;
  assign alu_operand2             = op2_q;
  assign illegal_instruction_word = illegal_word_q;
  assign busy                     = (state != IDLE);

endmodule

// File: tb/tb_r_type_issue_unit.sv
// Directed bench for r_type_issue_unit with a register-file and ALU model.
module tb_r_type_issue_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr_word = 32'h0;
  logic [4:0]  rs1_index, rs2_index, rd_index;
  logic [31:0] rs1_value, rs2_value;
  logic [2:0]  alu_subfunction_3;
  logic [6:0]  alu_subfunction_7;
  logic [31:0] alu_operand1, alu_operand2;
  logic        alu_error;
  logic [31:0] alu_result = 32'h0;
  logic        rd_write_enable;
  logic [31:0] rd_write_data;
  logic        retire, illegal_instruction, busy;
  logic [31:0] illegal_instruction_word;

  logic [31:0] rf [32] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_data = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  r_type_issue_unit dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .alu_subfunction_3(alu_subfunction_3), .alu_subfunction_7(alu_subfunction_7),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_error(alu_error), .alu_result(alu_result),
    .rd_write_enable(rd_write_enable), .rd_index(rd_index), .rd_write_data(rd_write_data),
    .retire(retire), .illegal_instruction(illegal_instruction),
    .illegal_instruction_word(illegal_instruction_word), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, x0 hard-wired to zero, bench preload port
  assign rs1_value = (rs1_index == 5'd0) ? 32'h0 : rf[rs1_index];
  assign rs2_value = (rs2_index == 5'd0) ? 32'h0 : rf[rs2_index];
  always @(posedge clk) begin
    if (pl_en) rf[pl_idx] <= pl_data;
    else if (rd_write_enable) rf[rd_index] <= rd_write_data;
  end

  // Reference R-type ALU: combinational error, registered result
  function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    alu_calc = (f7 == 7'h20) ? a - b : a + b;
      3'd1:    alu_calc = a << b[4:0];
      3'd2:    alu_calc = 32'($signed(a) < $signed(b));
      3'd3:    alu_calc = 32'(a < b);
      3'd4:    alu_calc = a ^ b;
      3'd5:    alu_calc = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu_calc = a | b;
      default: alu_calc = a & b;
    endcase
  endfunction

  assign alu_error = !((alu_subfunction_7 == 7'h00) ||
                       ((alu_subfunction_7 == 7'h20) &&
                        ((alu_subfunction_3 == 3'd0) || (alu_subfunction_3 == 3'd5))));
  always @(posedge clk)
    alu_result <= alu_calc(alu_subfunction_3, alu_subfunction_7, alu_operand1, alu_operand2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_data = val;
    tick();
    pl_en = 1'b0;
  endtask

  // Offer a word for exactly one accepting edge; returns in DECODE
  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1;
    instr_word  = w;
    tick();
    instr_valid = 1'b0;
    instr_word  = 32'hDEAD_BEEF;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illword", illegal_instruction_word, 32'h0);
    chk("rst_wen", 32'(rd_write_enable), 32'd0);
    reset = 1'b0;
    preload(5'd1, 32'hF0F0_F0F0);
    preload(5'd2, 32'h0FF0_0FF0);

    // XOR x3 = x1 ^ x2
    issue(32'h0020_C1B3);
    chk("xor_dec_ready", 32'(instr_ready), 32'd0);
    chk("xor_rs1", 32'(rs1_index), 32'd1);
    chk("xor_rs2", 32'(rs2_index), 32'd2);
    chk("xor_dec_wen", 32'(rd_write_enable), 32'd0);
    tick();
    chk("xor_f3", 32'(alu_subfunction_3), 32'd4);
    chk("xor_f7", 32'(alu_subfunction_7), 32'd0);
    chk("xor_op1", alu_operand1, 32'hF0F0_F0F0);
    chk("xor_op2", alu_operand2, 32'h0FF0_0FF0);
    chk("xor_exe_retire", 32'(retire), 32'd0);
    tick();
    chk("xor_wen", 32'(rd_write_enable), 32'd1);
    chk("xor_rd", 32'(rd_index), 32'd3);
    chk("xor_wdata", rd_write_data, 32'hFF00_FF00);
    chk("xor_retire", 32'(retire), 32'd1);
    chk("xor_illegal", 32'(illegal_instruction), 32'd0);
    tick();
    chk("xor_rf3", rf[3], 32'hFF00_FF00);
    chk("xor_idle_busy", 32'(busy), 32'd0);
    chk("xor_idle_retire", 32'(retire), 32'd0);

    // Non-OP opcode goes DECODE -> ILLEGAL, never EXECUTE
    issue(32'h0000_0013);
    chk("nop_dec_illegal", 32'(illegal_instruction), 32'd0);
    tick();
    chk("nop_illegal", 32'(illegal_instruction), 32'd1);
    chk("nop_illword", illegal_instruction_word, 32'h0000_0013);
    chk("nop_wen", 32'(rd_write_enable), 32'd0);
    chk("nop_retire", 32'(retire), 32'd0);
    tick();
    chk("nop_pulse_end", 32'(illegal_instruction), 32'd0);
    chk("nop_word_held", illegal_instruction_word, 32'h0000_0013);

    // ALU-reported error: funct7 0100000 with funct3 100
    issue(32'h4020_C1B3);
    tick();
    chk("aerr_exe_illegal", 32'(illegal_instruction), 32'd0);
    chk("aerr_f7", 32'(alu_subfunction_7), 32'h20);
    tick();
    chk("aerr_illegal", 32'(illegal_instruction), 32'd1);
    chk("aerr_illword", illegal_instruction_word, 32'h4020_C1B3);
    chk("aerr_wen", 32'(rd_write_enable), 32'd0);
    chk("aerr_retire", 32'(retire), 32'd0);
    tick();

    // rd = x0: retires but never writes
    issue(32'h0020_C033);
    tick();
    tick();
    chk("x0_retire", 32'(retire), 32'd1);
    chk("x0_wen", 32'(rd_write_enable), 32'd0);
    chk("x0_rd", 32'(rd_index), 32'd0);
    tick();

    // Back-to-back: x3 = x1 ^ x2, then x4 = x3 ^ x1 using the new x3
    preload(5'd3, 32'h0);
    instr_valid = 1'b1;
    instr_word  = 32'h0020_C1B3;
    tick();
    instr_word = 32'h0011_C233;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!instr_ready && cycles < 10);
    tick();
    instr_valid = 1'b0;
`ifdef R_TYPE_ISSUE_OVERLAP_EN
    chk("b2b_latency", 32'(cycles + 1), 32'd3);
`else
    chk("b2b_latency", 32'(cycles + 1), 32'd4);
`endif
    chk("b2b_rf3", rf[3], 32'hFF00_FF00);
    chk("b2b_rs1", 32'(rs1_index), 32'd3);
    tick();
    tick();
    chk("b2b_rd", 32'(rd_index), 32'd4);
    chk("b2b_wdata", rd_write_data, 32'h0FF0_0FF0);
    chk("b2b_retire", 32'(retire), 32'd1);
    tick();

    // Reset asserted mid-cycle while in EXECUTE
    issue(32'h0020_C2B3);
    tick();
    chk("rx_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_op1", alu_operand1, 32'h0);
    chk("rx_rs1", 32'(rs1_index), 32'd0);
    chk("rx_illword", illegal_instruction_word, 32'h0);
    chk("rx_wen", 32'(rd_write_enable), 32'd0);
    chk("rx_retire", 32'(retire), 32'd0);
    chk("rx_illegal", 32'(illegal_instruction), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rx_ready_after", 32'(instr_ready), 32'd1);
    chk("rx_rf5", rf[5], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
